// File: rtl/tour_cmd_sequencer.sv
// Queued move-command sequencer: buffers up to DEPTH commands and issues them to
// RemoteComm one at a time, waiting for transmit-complete and acknowledge on each.
module tour_cmd_sequencer #(
  parameter int         DEPTH      = 8,
  parameter int         TMO_CYCLES = 1000000,
  parameter logic [7:0] ACK_VAL    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [15:0]                  wr_data,
  input  logic                         clr,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         cmd_snt,
  input  logic                         resp_rdy,
  input  logic [7:0]                   resp,
  output logic [15:0]                  cmd,
  output logic                         snd_cmd,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic [$clog2(DEPTH+1)-1:0]   idx
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TMO_CYCLES + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_NAK   = 2'b01;
  localparam logic [1:0] EC_TMO   = 2'b10;
  localparam logic [1:0] EC_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SNT  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  state_t         state_r, state_s;
  logic [15:0]    queue_r [DEPTH];
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [CW-1:0]  idx_r, idx_s;
  logic [TW-1:0]  tmo_r, tmo_s;
  logic [15:0]    cmd_r, cmd_s;
  logic           snd_cmd_r, snd_cmd_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           err_r, err_s;
  logic [1:0]     err_code_r, err_code_s;
  logic           wr_s;

  // Command storage; contents are don't-care after reset since cnt gates every read
  always_ff @(posedge clk) begin
    if (wr_s) begin
      queue_r[cnt_r[AW-1:0]] <= wr_data;
    end
  end

  // Next-state and next-output decode for the sequencer
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    tmo_s      = tmo_r;
    cmd_s      = cmd_r;
    snd_cmd_s  = 1'b0;
    done_s     = done_r;
    err_s      = err_r;
    err_code_s = err_code_r;
    wr_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (clr) begin
          state_s    = ST_IDLE;
          cnt_s      = CNT_ZERO;
          idx_s      = CNT_ZERO;
          done_s     = 1'b0;
          err_s      = 1'b0;
          err_code_s = EC_NONE;
        end else if (start) begin
          idx_s      = CNT_ZERO;
          err_s      = 1'b0;
          err_code_s = EC_NONE;
          if (cnt_r == CNT_ZERO) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_SEND;
            done_s  = 1'b0;
          end
        end else if (wr_en && (cnt_r < CNT_MAX)) begin
          wr_s  = 1'b1;
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          state_s = state_r;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_s    = ST_ERR;
          err_s      = 1'b1;
          err_code_s = EC_ABORT;
        end else begin
          cmd_s     = queue_r[idx_r[AW-1:0]];
          snd_cmd_s = 1'b1;
          tmo_s     = TMO_ZERO;
          state_s   = ST_WAIT_SNT;
        end
      end
      ST_WAIT_SNT: begin
        if (abort) begin
          state_s    = ST_ERR;
          err_s      = 1'b1;
          err_code_s = EC_ABORT;
        end else if (cmd_snt) begin
          tmo_s   = TMO_ZERO;
          state_s = ST_WAIT_RESP;
        end else if (tmo_r == TMO_LAST) begin
          state_s    = ST_ERR;
          err_s      = 1'b1;
          err_code_s = EC_TMO;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
      ST_WAIT_RESP: begin
        if (abort) begin
          state_s    = ST_ERR;
          err_s      = 1'b1;
          err_code_s = EC_ABORT;
        end else if (resp_rdy) begin
          if (resp == ACK_VAL) begin
            idx_s = idx_r + CNT_ONE;
            if (idx_s == cnt_r) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_SEND;
            end
          end else begin
            state_s    = ST_ERR;
            err_s      = 1'b1;
            err_code_s = EC_NAK;
          end
        end else if (tmo_r == TMO_LAST) begin
          state_s    = ST_ERR;
          err_s      = 1'b1;
          err_code_s = EC_TMO;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        done_s  = 1'b0;
        err_s   = 1'b0;
      end
    endcase
    busy_s = (state_s == ST_SEND) || (state_s == ST_WAIT_SNT) || (state_s == ST_WAIT_RESP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      idx_r      <= CNT_ZERO;
      tmo_r      <= TMO_ZERO;
      cmd_r      <= 16'h0000;
      snd_cmd_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= EC_NONE;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      tmo_r      <= tmo_s;
      cmd_r      <= cmd_s;
      snd_cmd_r  <= snd_cmd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      err_code_r <= err_code_s;
    end
  end

  assign cmd      = cmd_r;
  assign snd_cmd  = snd_cmd_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign err_code = err_code_r;
  assign cnt      = cnt_r;
  assign idx      = idx_r;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Scenario bench for tour_cmd_sequencer: expected commands are queued as they are
// loaded and popped by a monitor each time the sequencer strobes snd_cmd.
module tb_tour_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 100;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n, wr_en, clr, start, abort, cmd_snt, resp_rdy;
  logic [15:0]   wr_data;
  logic [7:0]    resp;
  logic [15:0]   cmd;
  logic          snd_cmd, busy, done, err;
  logic [1:0]    err_code;
  logic [CW-1:0] cnt, idx;

  int checks = 0;
  int errors = 0;
  int snd_count = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TMO_CYCLES(TMO), .ACK_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .abort(abort), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy),
    .resp(resp), .cmd(cmd), .snd_cmd(snd_cmd), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .cnt(cnt), .idx(idx)
  );

  // Scoreboard monitor: every strobe must match the next expected command
  always @(negedge clk) begin
    if (rst_n === 1'b1 && snd_cmd === 1'b1) begin
      snd_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL snd_unexpected: got cmd=%h strobe, required no strobe", cmd);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (cmd !== e) begin
          errors++;
          $display("FAIL snd_cmd_value: got %h, required %h", cmd, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v);
    wr_en = 1'b1; wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for a strobe, then plays RemoteComm: cmd_snt, then response r
  task automatic serve(input logic [7:0] r);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (snd_cmd === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL serve_wait: got no snd_cmd within 20 clocks, required strobe");
    end else begin
      cmd_snt = 1'b1;
      step();
      cmd_snt = 1'b0; resp_rdy = 1'b1; resp = r;
      step();
      resp_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; clr = 1'b0; start = 1'b0;
    abort = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = 8'h00;
    step(3);
    checks++;
    if ({cmd, snd_cmd, busy, done, err, err_code, cnt, idx} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {cmd, snd_cmd, busy, done, err, err_code, cnt, idx});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_two_acks();
    int base;
    do_clr();
    load(16'h43F2); load(16'h5001);
    checks++;
    if (cnt !== 3'd2) begin errors++; $display("FAIL load_cnt: got %0d, required 2", cnt); end
    exp_q.push_back(16'h43F2); exp_q.push_back(16'h5001);
    base = snd_count;
    pulse_start();
    checks++;
    if (snd_cmd !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_latency_a: got snd=%b busy=%b, required snd=0 busy=1", snd_cmd, busy);
    end
    step();
    checks++;
    if (snd_cmd !== 1'b1) begin errors++; $display("FAIL start_latency_b: got snd=%b, required 1", snd_cmd); end
    serve(8'hA5); serve(8'hA5);
    checks++;
    if (idx !== 3'd2 || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL two_acks_status: got idx=%0d done=%b err=%b busy=%b, required 2 1 0 0", idx, done, err, busy);
    end
    step(3);
    checks++;
    if (snd_count - base !== 2 || cmd !== 16'h5001) begin
      errors++; $display("FAIL two_acks_pulses: got %0d pulses cmd=%h, required 2 and 5001", snd_count - base, cmd);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(16'h43F2); exp_q.push_back(16'h5001);
    pulse_start();
    checks++;
    if (done !== 1'b0 || idx !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_clear: got done=%b idx=%0d busy=%b, required 0 0 1", done, idx, busy);
    end
    serve(8'hA5); serve(8'hA5);
    checks++;
    if (done !== 1'b1 || idx !== 3'd2 || exp_q.size() != 0) begin
      errors++; $display("FAIL restart_done: got done=%b idx=%0d left=%0d, required 1 2 0", done, idx, exp_q.size());
    end
  endtask

  task automatic test_nak();
    int base;
    do_clr();
    load(16'h1111); load(16'h2222); load(16'h3333);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    base = snd_count;
    pulse_start();
    serve(8'hA5); serve(8'h5A);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || idx !== 3'd1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nak_status: got err=%b code=%b idx=%0d done=%b busy=%b, required 1 01 1 0 0",
                         err, err_code, idx, done, busy);
    end
    step(10);
    checks++;
    if (snd_count - base !== 2) begin errors++; $display("FAIL nak_pulses: got %0d, required 2", snd_count - base); end
  endtask

  task automatic test_timeout();
    int n;
    do_clr();
    load(16'hABCD);
    exp_q.push_back(16'hABCD);
    pulse_start();
    step();
    checks++;
    if (snd_cmd !== 1'b1) begin errors++; $display("FAIL tmo_snd: got %b, required 1", snd_cmd); end
    resp_rdy = 1'b1; resp = 8'hA5;
    step();
    resp_rdy = 1'b0;
    n = 1;
    while (err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n !== TMO || err_code !== 2'b10 || busy !== 1'b0 || idx !== 3'd0) begin
      errors++; $display("FAIL timeout: got clocks=%0d code=%b busy=%b idx=%0d, required 100 10 0 0", n, err_code, busy, idx);
    end
  endtask

  task automatic test_full_and_empty();
    int base;
    do_clr();
    for (int i = 0; i < DEPTH + 2; i++) load(16'h0100 + 16'(i));
    checks++;
    if (cnt !== 3'(DEPTH)) begin errors++; $display("FAIL full_cnt: got %0d, required %0d", cnt, DEPTH); end
    clr = 1'b1; wr_en = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0; start = 1'b0;
    checks++;
    if (cnt !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL clr_wins: got cnt=%0d busy=%b done=%b, required 0 0 0", cnt, busy, done);
    end
    base = snd_count;
    pulse_start();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL empty_start: got done=%b busy=%b err=%b, required 1 0 0", done, busy, err);
    end
    step(5);
    checks++;
    if (snd_count !== base) begin errors++; $display("FAIL empty_pulses: got %0d, required 0", snd_count - base); end
  endtask

  task automatic test_abort_priority();
    do_clr();
    load(16'h7777); load(16'h8888);
    exp_q.push_back(16'h7777);
    pulse_start();
    step();
    cmd_snt = 1'b1;
    step();
    cmd_snt = 1'b0; abort = 1'b1; resp_rdy = 1'b1; resp = 8'hA5;
    step();
    abort = 1'b0; resp_rdy = 1'b0;
    checks++;
    if (err !== 1'b1 || err_code !== 2'b11 || idx !== 3'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_prio: got err=%b code=%b idx=%0d done=%b, required 1 11 0 0", err, err_code, idx, done);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (err_code !== 2'b11 || err !== 1'b1) begin
      errors++; $display("FAIL abort_idle: got err=%b code=%b, required 1 11", err, err_code);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_clr();
    load(16'hC0DE); load(16'hBEEF);
    exp_q.push_back(16'hC0DE);
    pulse_start();
    step();
    cmd_snt = 1'b1;
    step();
    cmd_snt = 1'b0;
    base = snd_count;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd, snd_cmd, busy, done, err, err_code, cnt, idx} !== 28'h0) begin
      errors++; $display("FAIL reset_mid: got %h, required 0", {cmd, snd_cmd, busy, done, err, err_code, cnt, idx});
    end
    step(2);
    rst_n = 1'b1;
    step(20);
    checks++;
    if (snd_count !== base || cnt !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got pulses=%0d cnt=%0d busy=%b, required 0 0 0", snd_count - base, cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_two_acks();
    test_back_to_back();
    test_nak();
    test_timeout();
    test_full_and_empty();
    test_abort_priority();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tour_cmd_sequencer.md
TOUR_CMD_SEQUENCER -- requirements
Module: tour_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, max queued move commands (legal 2..64).
REQ-002 SHALL have parameter TMO_CYCLES, default 1000000, per-phase handshake timeout in clocks.
REQ-003 SHALL have parameter ACK_VAL, default 8'hA5, response value counted as positive acknowledge.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  append wr_data to command queue.
REQ-007 SHALL have port wr_data  input  16  move command to append.
REQ-008 SHALL have port clr  input  1  empty queue and clear status.
REQ-009 SHALL have port start  input  1  begin issuing queued commands from entry 0.
REQ-010 SHALL have port abort  input  1  terminate active sequence.
REQ-011 SHALL have port cmd_snt  input  1  RemoteComm pulse: command fully transmitted.
REQ-012 SHALL have port resp_rdy  input  1  RemoteComm pulse: response byte valid.
REQ-013 SHALL have port resp  input  8  response byte from Knight.
REQ-014 SHALL have port cmd  output  16  command to RemoteComm, registered.
REQ-015 SHALL have port snd_cmd  output  1  one-clock send strobe to RemoteComm, registered.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE/DONE/ERR.
REQ-017 SHALL have port done  output  1  level, all queued commands acknowledged.
REQ-018 SHALL have port err  output  1  level, sequence failed.
REQ-019 SHALL have port err_code  output  2  00 none, 01 NAK, 10 timeout, 11 abort.
REQ-020 SHALL have ports cnt and idx  output  $clog2(DEPTH+1) each  entries loaded / entries acknowledged.

Function
REQ-021 States SHALL be IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE, ERR; DONE and ERR behave as IDLE for loading, clr and start.
REQ-022 wr_en when not busy and cnt<DEPTH SHALL write entry[cnt] and increment cnt; wr_en when full or busy SHALL be ignored.
REQ-023 clr when not busy SHALL zero cnt, idx, done, err, err_code and go IDLE; clr wins over simultaneous wr_en/start; clr when busy ignored.
REQ-024 start when not busy and cnt>0 SHALL zero idx, done, err, err_code and enter SEND; start while busy ignored.
REQ-025 start with cnt==0 SHALL go directly to DONE (done=1 next clock, no snd_cmd).
REQ-026 SEND SHALL load cmd<=entry[idx], pulse snd_cmd for exactly one clock, enter WAIT_SNT; first snd_cmd high two clocks after start sampled.
REQ-027 cmd SHALL remain stable from snd_cmd until next SEND, and hold last value after DONE/ERR.
REQ-028 WAIT_SNT on cmd_snt SHALL enter WAIT_RESP; resp_rdy seen in WAIT_SNT ignored.
REQ-029 WAIT_RESP on resp_rdy with resp==ACK_VAL SHALL increment idx, then DONE if new idx==cnt, else SEND.
REQ-030 WAIT_RESP on resp_rdy with resp!=ACK_VAL SHALL enter ERR, err_code=01, idx unchanged.
REQ-031 Timeout counter SHALL clear on entry to WAIT_SNT and WAIT_RESP, count each clock there; reaching TMO_CYCLES SHALL enter ERR, err_code=10.
REQ-032 abort while busy SHALL enter ERR, err_code=11 next clock; abort when not busy ignored.
REQ-033 Same-cycle priority SHALL be abort > resp_rdy > timeout.
REQ-034 done and err SHALL never be high together; both held until clr or start.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, cmd=0, snd_cmd=0, busy=0, done=0, err=0, err_code=00, cnt=0, idx=0; queue contents don't-care.
REQ-036 Reset mid-sequence SHALL abandon the sequence with no further snd_cmd; queue empty after release.

Verification
REQ-037 Load 16'h43F2, 16'h5001, start, model acks A5 each -> two snd_cmd pulses with those values in order, idx=2, done=1, err=0.
REQ-038 Load 3 cmds, resp 8'h5A on second -> err=1, err_code=01, idx=1, exactly two snd_cmd pulses.
REQ-039 TMO_CYCLES=100, withhold cmd_snt -> err_code=10 exactly 100 clocks after WAIT_SNT entry, busy=0.
REQ-040 Write DEPTH+2 entries -> cnt=DEPTH; start with cnt=0 after clr -> done=1, no snd_cmd.
REQ-041 abort and resp_rdy(A5) same clock in WAIT_RESP -> err_code=11, idx unchanged.
REQ-042 rst_n low during WAIT_RESP -> all outputs zero, cnt=0, no snd_cmd after release.
